// File: rtl/tensor_dense_engine.sv
// tensor_dense_engine
//   Fully-connected int8 layer engine. For every output neuron (row) it loads
//   the bias word, then streams WPR weight words and WPR activation words in
//   parallel. Each word pair contributes 4 signed 8x8 products to a 32-bit
//   accumulator. The result is requantized (arithmetic shift, optional ReLU,
//   saturation to int8) and emitted on a valid/ready stream.
//
// Ports
//   clk        : single clock, rising edge
//   rst        : synchronous, active-low reset
//   start      : one-cycle request to run a whole layer (accepted in IDLE only)
//   busy       : high while a layer is in progress (BIAS..OUT)
//   done       : one-cycle pulse after the last output handshake
//   mem_ren    : tensor memory read enable (data returns one cycle later)
//   mem_addr   : tensor memory word address
//   mem_rdata  : tensor memory read data (bias word or 4 packed weights)
//   act_ren    : activation buffer read enable (1-cycle latency)
//   act_addr   : activation buffer word address
//   act_rdata  : 4 packed int8 activations
//   out_valid  : result valid
//   out_ready  : downstream ready
//   out_data   : requantized int8 result
//   out_idx    : output neuron index of out_data
module tensor_dense_engine #(
  parameter int IN_DIM  = 3600,
  parameter int OUT_DIM = 64,
  parameter int W_BASE  = 0,
  parameter int B_BASE  = 57600,
  parameter int SHIFT   = 8,
  parameter int RELU    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               mem_ren,
  output logic [31:0]        mem_addr,
  input  logic [31:0]        mem_rdata,
  output logic               act_ren,
  output logic [31:0]        act_addr,
  input  logic [31:0]        act_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [7:0]  out_data,
  output logic [15:0]        out_idx
);

  localparam int          WPR       = IN_DIM / 4;
  localparam logic [31:0] WORD_LAST = 32'(WPR - 1);
  localparam logic [15:0] ROW_LAST  = 16'(OUT_DIM - 1);

  typedef enum logic [2:0] {IDLE, BIAS, MAC, DRAIN, OUT, FIN} state_t;

  state_t             state, state_nxt;
  logic [15:0]        row;
  logic [31:0]        word;
  logic signed [31:0] acc;
  logic signed [31:0] dot;
  logic signed [31:0] shifted;
  logic signed [15:0] prod [4];
  logic               load_bias;
  logic               acc_en;

  // Next-state logic and all memory/handshake controls. Reads are only ever
  // issued from BIAS and MAC, so a stall in OUT naturally stops memory traffic.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    mem_ren   = 1'b0;
    mem_addr  = '0;
    act_ren   = 1'b0;
    act_addr  = '0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = BIAS;
      end
      BIAS: begin
        busy      = 1'b1;
        mem_ren   = 1'b1;
        mem_addr  = 32'(B_BASE) + 32'(row);
        state_nxt = MAC;
      end
      MAC: begin
        busy     = 1'b1;
        mem_ren  = 1'b1;
        act_ren  = 1'b1;
        mem_addr = 32'(W_BASE) + 32'(row) * 32'(WPR) + word;
        act_addr = word;
        if (word == WORD_LAST) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy      = 1'b1;
        state_nxt = OUT;
      end
      OUT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = (row == ROW_LAST) ? FIN : BIAS;
      end
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Sum of the four lane products of the word pair returned this cycle.
  // Operands are sign-extended to 16 bits so each product is exact.
  always_comb begin
    dot = '0;
    for (int i = 0; i < 4; i++) begin
      prod[i] = 16'($signed(mem_rdata[8*i +: 8])) * 16'($signed(act_rdata[8*i +: 8]));
      dot     = dot + 32'(prod[i]);
    end
  end

  // Requantization of the finished accumulator; outputs are zero outside OUT.
  assign shifted = acc >>> SHIFT;

  always_comb begin
    out_data = '0;
    out_idx  = '0;
    if (state == OUT) begin
      out_idx = row;
      if (RELU != 0 && shifted < 0)
        out_data = '0;
      else if (shifted > 32'sd127)
        out_data = 8'sd127;
      else if (shifted < -32'sd128)
        out_data = -8'sd128;
      else
        out_data = shifted[7:0];
    end
  end

  // State, counters and accumulator. Read data lags the issue by one cycle,
  // so load_bias/acc_en remember what was issued last cycle: the bias lands
  // during MAC word 0 and the final weight word lands during DRAIN.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      row       <= '0;
      word      <= '0;
      acc       <= '0;
      load_bias <= 1'b0;
      acc_en    <= 1'b0;
    end else begin
      state     <= state_nxt;
      load_bias <= (state == BIAS);
      acc_en    <= (state == MAC);

      if (load_bias)
        acc <= $signed(mem_rdata);
      else if (acc_en)
        acc <= acc + dot;

      if (state == MAC)
        word <= word + 32'd1;
      else
        word <= '0;

      if (state == IDLE && start)
        row <= '0;
      else if (state == OUT && out_ready && row != ROW_LAST)
        row <= row + 16'd1;
    end
  end

endmodule

// File: doc/tensor_dense_engine.md
TENSOR_DENSE_ENGINE -- requirements
Module: tensor_dense_engine

Interface
REQ-001 SHALL have parameter IN_DIM, default 3600, meaning input vector length in int8 elements; must be a multiple of 4.
REQ-002 SHALL have parameter OUT_DIM, default 64, meaning output neurons (weight rows).
REQ-003 SHALL have parameter W_BASE, default 0, meaning tensor word address of weight row 0, element 0.
REQ-004 SHALL have parameter B_BASE, default 57600, meaning tensor word address of bias 0.
REQ-005 SHALL have parameter SHIFT, default 8, meaning arithmetic right-shift applied for requantization.
REQ-006 SHALL have parameter RELU, default 1, meaning 1 clamps negative results to 0.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-008 SHALL have port rst, input, 1 bit: reset, synchronous and active-low (0 = reset).
REQ-009 SHALL have port start, input, 1 bit: one-cycle request to run a full layer.
REQ-010 SHALL have port busy, output, 1 bit: high from the cycle after an accepted start until done.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse after the last output handshake.
REQ-012 SHALL have ports mem_ren (output, 1), mem_addr (output, 32) and mem_rdata (input, 32): tensor memory read port, with data valid one cycle after mem_ren.
REQ-013 SHALL have ports act_ren (output, 1), act_addr (output, 32) and act_rdata (input, 32): activation buffer read port, with 1-cycle latency and 4 int8 values packed per word.
REQ-014 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_data (output, 8, signed) and out_idx (output, 16): result stream.

Function
REQ-015 SHALL define WPR = IN_DIM/4; word k of an activation or weight row carries element 4k+i in bits [8i+7:8i]; all elements are signed int8.
REQ-016 SHALL use FSM states IDLE, BIAS, MAC, DRAIN, OUT, FIN.
- IDLE->BIAS on start.
- BIAS->MAC after 1 cycle.
- MAC->DRAIN after WPR cycles.
- DRAIN->OUT after 1 cycle.
- OUT->BIAS (next row) or OUT->FIN (last row) on out_valid&&out_ready.
- FIN->IDLE after 1 cycle, with done=1 during FIN.
REQ-017 SHALL, in BIAS for row r, assert mem_ren with mem_addr=B_BASE+r and act_ren=0.
REQ-018 SHALL, in MAC cycle k (0..WPR-1), assert mem_ren and act_ren together, with mem_addr=W_BASE+r*WPR+k and act_addr=k.
REQ-019 SHALL assert mem_ren and act_ren in no state other than BIAS and MAC.
REQ-020 SHALL load acc (32-bit signed) with mem_rdata in the cycle following BIAS.
REQ-021 SHALL, in each cycle following a MAC issue, add the sum of the 4 signed 8x8 lane products to acc; the last word accumulates during DRAIN.
REQ-022 SHALL let acc wrap modulo 2^32 with no overflow flag.
REQ-023 SHALL compute the result in OUT as: v = acc >>> SHIFT (arithmetic floor); if RELU and v<0 then v=0; saturate v to [-128,127].
REQ-024 SHALL drive out_data=v and out_idx=r in OUT, with out_valid held high and out_data/out_idx stable until out_ready.
REQ-025 SHALL issue no memory reads while stalled in OUT.
REQ-026 SHALL assert out_valid first exactly WPR+2 cycles after entering BIAS.
REQ-027 SHALL ignore start while busy, and SHALL ignore start asserted in the same cycle as done.
REQ-028 SHALL hold busy=1 in states BIAS through OUT and busy=0 in IDLE and FIN.

Reset
REQ-029 SHALL, while rst=0 at a clock edge, go to IDLE and drive busy=0, done=0, mem_ren=0, act_ren=0, out_valid=0, mem_addr=0, act_addr=0, out_data=0, out_idx=0, and clear acc and the row/word counters.
REQ-030 SHALL, on reset mid-layer, abandon the layer with no done pulse; the next start re-runs from row 0.

Verification
REQ-031 SHALL cover this case (IN_DIM=8, OUT_DIM=2, SHIFT=0 for REQ-031..034): all weights and activations 0x01010101, biases 0 -> out_data 8 (idx 0), then 8 (idx 1), then a single done pulse.
REQ-032 SHALL cover this case: weights 0xFFFFFFFF, activations 0x7F7F7F7F, bias 0 -> RELU=1 gives 0; RELU=0 gives -128 (saturated from -1016).
REQ-033 SHALL cover this case: weights 0, bias 300, SHIFT=2 -> 75; bias -5, SHIFT=1, RELU=0 -> -3.
REQ-034 SHALL cover this case: hold out_ready=0 for 10 cycles in OUT -> out_valid=1 with data and idx stable, mem_ren=act_ren=0 throughout; output resumes on release.
REQ-035 SHALL cover this case: rst=0 during MAC of row 0 -> all outputs 0 next cycle, no done; a new start then produces correct results from idx 0.
REQ-036 SHALL cover this case (default parameters): mem_addr sequence 57600, 0..899 for row 0, then 57601, 900..1799 for row 1; act_addr is 0..899 for every row.
